debounce_multi: RTL and testbench
=================================

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independent input channels (legal range 1..32).
REQ-002 The block SHALL have parameter STABLE_CNT, default 10, giving the consecutive agreeing samples needed to accept a new level (legal range 1..255).
REQ-003 The block SHALL have parameter TICK_DIV, default 1, giving clk_in cycles per sample tick (legal range 1..65535).
REQ-004 The block SHALL have parameters REPEAT_DELAY, default 50, and REPEAT_PERIOD, default 10, in ticks; both are used only under DEBOUNCE_REPEAT_EN.
REQ-005 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 din  input  N_CH  raw, asynchronous, bouncing inputs; one bit per channel.
REQ-008 level  output  N_CH  debounced, registered level per channel.
REQ-009 rise  output  N_CH  one-clk_in-cycle pulse on each accepted 0->1 transition of level.
REQ-010 fall  output  N_CH  one-clk_in-cycle pulse on each accepted 1->0 transition of level.
REQ-011 rpt  output  N_CH  one-cycle auto-repeat pulse while level is held high; constant 0 when repeat is compiled out.

Function
REQ-012 Each din bit SHALL pass through a two-flop synchroniser before any use.
REQ-013 A shared prescaler SHALL count 0..TICK_DIV-1 and assert the internal tick in the cycle its count equals TICK_DIV-1; with TICK_DIV=1, tick SHALL be asserted every cycle.
REQ-014 On each tick, per channel, if the synchronised bit equals level, the channel counter SHALL clear to 0.
REQ-015 On each tick, per channel, if the synchronised bit differs from level, the counter SHALL increment by 1.
REQ-016 When the counter increments to STABLE_CNT, level SHALL take the synchronised value and the counter SHALL clear, on that same edge.
REQ-017 The counter width SHALL be clog2(STABLE_CNT+1) and SHALL never wrap.
REQ-018 rise (or fall) SHALL be registered and high exactly in the cycle in which level first shows its new value, then low the next cycle.
REQ-019 With TICK_DIV=1, a din change settled before edge k SHALL appear on level and rise/fall after edge k+1+STABLE_CNT.
REQ-020 A disagreeing run shorter than STABLE_CNT ticks SHALL produce no level change and no pulse.
REQ-021 With STABLE_CNT=1, level SHALL follow the synchronised bit on the first tick after it differs.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on any set of channels SHALL each produce their own pulses in the same cycle.
REQ-023 rise and fall of one channel SHALL never be high in the same cycle.

Reset
REQ-024 While rst is low, the synchronisers, prescaler, per-channel counters, level, rise, fall, rpt and repeat counters SHALL all be 0.
REQ-025 Assertion of rst mid-count SHALL discard partial counts immediately, with no pulse emitted.
REQ-026 After rst deasserts, a din held high SHALL be accepted as a normal 0->1 transition, producing a rise pulse.

Configuration
REQ-027 With macro DEBOUNCE_REPEAT_EN defined, a per-channel repeat counter SHALL run on ticks while level is 1 and clear when level is 0.
REQ-028 Under DEBOUNCE_REPEAT_EN, rpt SHALL pulse for one cycle REPEAT_DELAY ticks after rise, then every REPEAT_PERIOD ticks while level stays 1.
REQ-029 Without DEBOUNCE_REPEAT_EN, the repeat logic SHALL be absent, rpt SHALL be tied to 0, and the REPEAT_* parameters SHALL be ignored.

Verification
REQ-030 Bench: N_CH=4, STABLE_CNT=4, TICK_DIV=1; din[0] 0->1 before edge 0 -> level[0]=1 and rise[0]=1 after edge 5, rise[0]=0 after edge 6.
REQ-031 Bench: same config; din[1] high for 3 cycles then low -> level[1], rise[1] and fall[1] remain 0 throughout.
REQ-032 Bench: same config; din=4'b1111 simultaneously -> all four rise bits high in the same single cycle; later din=0 -> all four fall bits high together after 6 edges.
REQ-033 Bench: TICK_DIV=5, STABLE_CNT=3; din[2] rises -> level[2] rises 15+2 cycles later (within one prescaler phase); no early pulse.
REQ-034 Bench: rst driven low when din[3] has 2 of 4 agreeing samples -> all outputs 0 immediately; after release, the full 4-sample count is required.
REQ-035 Bench: DEBOUNCE_REPEAT_EN, TICK_DIV=1, REPEAT_DELAY=8, REPEAT_PERIOD=3; hold din[0] high -> rpt[0] at 8, 11, 14 cycles after rise[0]; rpt stops once fall[0] occurs.

Source files
------------

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Purpose:
//   Multi-channel switch debouncer. Every raw input bit is brought into the
//   clk_in domain through a two-flop synchroniser, then sampled on a shared
//   prescaled tick. A channel only accepts a new level after STABLE_CNT
//   consecutive ticks that disagree with the current level; any agreeing
//   sample in between restarts that count. Accepted transitions produce
//   single-cycle rise/fall pulses that line up with the level change.
//
// Optional feature (macro DEBOUNCE_REPEAT_EN):
//   When defined, each channel gets an auto-repeat counter. While level is
//   held high, rpt pulses REPEAT_DELAY ticks after the rise and then every
//   REPEAT_PERIOD ticks. When undefined, the repeat logic is not built and
//   rpt is tied to 0 (REPEAT_* parameters are then ignored).
//
// Parameters:
//   N_CH          number of independent channels (1..32)
//   STABLE_CNT    consecutive disagreeing ticks needed to accept (1..255)
//   TICK_DIV      clk_in cycles per sample tick (1..65535)
//   REPEAT_DELAY  ticks from rise to first rpt pulse (repeat build only)
//   REPEAT_PERIOD ticks between later rpt pulses (repeat build only)
//
// Ports:
//   clk_in  in   1     sole clock, rising edge
//   rst     in   1     asynchronous, active-low reset
//   din     in   N_CH  raw bouncing inputs, one bit per channel
//   level   out  N_CH  debounced level (registered)
//   rise    out  N_CH  one-cycle pulse on an accepted 0->1 change
//   fall    out  N_CH  one-cycle pulse on an accepted 1->0 change
//   rpt     out  N_CH  auto-repeat pulse while level is high (0 if compiled out)
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CNT    = 10,
  parameter int TICK_DIV      = 1,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] rpt
);

  // Stability counter is sized to hold STABLE_CNT, but it is cleared on the
  // increment that reaches STABLE_CNT, so it never actually wraps.
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  // A one-cycle prescaler still needs a 1-bit register; it simply stays 0.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
`else
  // Repeat parameters are intentionally unused in this build.
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for all raw inputs
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared sample-tick prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_pre;
  logic          w_tick;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce state
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          w_diff;
    logic          w_accept;
    logic          w_level_next;

    assign w_diff       = r_sync2[gi] ^ r_level;
    // Accept on the tick whose increment would make the count STABLE_CNT.
    assign w_accept     = w_tick & w_diff & (r_cnt == CNT_LAST);
    assign w_level_next = w_accept ? r_sync2[gi] : r_level;

    always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        // Pulses are registered alongside level so they appear together.
        r_rise  <= w_accept &  r_sync2[gi];
        r_fall  <= w_accept & ~r_sync2[gi];
        r_level <= w_level_next;
        if (w_tick) begin
          if (!w_diff || w_accept) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end

    assign level[gi] = r_level;
    assign rise[gi]  = r_rise;
    assign fall[gi]  = r_fall;

`ifdef DEBOUNCE_REPEAT_EN
    logic [RW-1:0] r_rcnt;
    logic          r_rphase;   // 0: waiting for first repeat, 1: periodic
    logic          r_rpt;
    logic          w_hold;
    logic [RW-1:0] w_rcnt_inc;
    logic [RW-1:0] w_rtarget;

    // Count only while level is high and is not being dropped on this edge,
    // so no repeat pulse can coincide with the fall pulse.
    assign w_hold     = r_level & w_level_next;
    assign w_rcnt_inc = r_rcnt + RW'(1);
    assign w_rtarget  = r_rphase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);

    always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
        r_rcnt   <= '0;
        r_rphase <= 1'b0;
        r_rpt    <= 1'b0;
      end else begin
        r_rpt <= 1'b0;
        if (!w_hold) begin
          r_rcnt   <= '0;
          r_rphase <= 1'b0;
        end else if (w_tick) begin
          if (w_rcnt_inc == w_rtarget) begin
            r_rpt    <= 1'b1;
            r_rcnt   <= '0;
            r_rphase <= 1'b1;
          end else begin
            r_rcnt <= w_rcnt_inc;
          end
        end
      end
    end

    assign rpt[gi] = r_rpt;
`else
    assign rpt[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//
// Self-checking bench for debounce_multi. Three instances share one clock:
//   u_a : N_CH=4, STABLE_CNT=4, TICK_DIV=1, REPEAT_DELAY=8, REPEAT_PERIOD=3
//   u_b : N_CH=4, STABLE_CNT=3, TICK_DIV=5
//   u_c : N_CH=2, STABLE_CNT=1, TICK_DIV=1
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Expected values are hand-computed cycle by cycle.
// Compile with +define+DEBOUNCE_REPEAT_EN to also check auto-repeat.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic [3:0] din_a = '0, level_a, rise_a, fall_a, rpt_a;
  logic [3:0] din_b = '0, level_b, rise_b, fall_b, rpt_b;
  logic [1:0] din_c = '0, level_c, rise_c, fall_c, rpt_c;

  debounce_multi #(
    .N_CH(4), .STABLE_CNT(4), .TICK_DIV(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) u_a (
    .clk_in(clk), .rst(rst_a), .din(din_a),
    .level(level_a), .rise(rise_a), .fall(fall_a), .rpt(rpt_a)
  );

  debounce_multi #(
    .N_CH(4), .STABLE_CNT(3), .TICK_DIV(5), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) u_b (
    .clk_in(clk), .rst(rst_b), .din(din_b),
    .level(level_b), .rise(rise_b), .fall(fall_b), .rpt(rpt_b)
  );

  debounce_multi #(
    .N_CH(2), .STABLE_CNT(1), .TICK_DIV(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) u_c (
    .clk_in(clk), .rst(rst_b), .din(din_c),
    .level(level_c), .rise(rise_c), .fall(fall_c), .rpt(rpt_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One record per clock: din applied before edge i, outputs expected after it.
  typedef struct {
    logic [3:0] din;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rpt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] d, input logic [3:0] l,
                              input logic [3:0] r, input logic [3:0] f,
                              input int n = 1);
    vec_t v;
    v.din = d; v.level = l; v.rise = r; v.fall = f; v.rpt = 4'b0000;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  initial begin
    // ---------------- vector table for u_a ----------------
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5);  // 0-4 : ch0 counting
    add(4'b0001, 4'b0001, 4'b0001, 4'b0000);     // 5   : accepted, rise
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000);     // 6   : rise drops
    add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 3);  // 7-9 : ch1 glitch, 3 samples
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4);  // 10-13
    add(4'b0000, 4'b0001, 4'b0000, 4'b0000, 5);  // 14-18: ch0 released
    add(4'b0000, 4'b0000, 4'b0000, 4'b0001);     // 19  : fall
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000);     // 20
    add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 5);  // 21-25: all channels
    add(4'b1111, 4'b1111, 4'b1111, 4'b0000);     // 26  : four rises together
    add(4'b1111, 4'b1111, 4'b0000, 4'b0000);     // 27
    add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 5);  // 28-32
    add(4'b0000, 4'b0000, 4'b0000, 4'b1111);     // 33  : four falls together
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000);     // 34
`ifdef DEBOUNCE_REPEAT_EN
    // ch0 high from edge 5 and stays through edge 18: repeats at 5+8, 5+11.
    vecs[13].rpt = 4'b0001;
    vecs[16].rpt = 4'b0001;
`endif

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("reset level_a", 32'(level_a), 32'h0);
    check("reset rise_a",  32'(rise_a),  32'h0);
    check("reset fall_a",  32'(fall_a),  32'h0);
    check("reset rpt_a",   32'(rpt_a),   32'h0);
    check("reset level_b", 32'(level_b), 32'h0);
    check("reset rpt_b",   32'(rpt_b),   32'h0);
    check("reset level_c", 32'(level_c), 32'h0);
    check("reset rpt_c",   32'(rpt_c),   32'h0);

    @(negedge clk);
    rst_a = 1'b1;

    // ---------------- table-driven run ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      din_a = vecs[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d level", i), 32'(level_a), 32'(vecs[i].level));
      check($sformatf("vec%0d rise", i),  32'(rise_a),  32'(vecs[i].rise));
      check($sformatf("vec%0d fall", i),  32'(fall_a),  32'(vecs[i].fall));
      check($sformatf("vec%0d rpt", i),   32'(rpt_a),   32'(vecs[i].rpt));
    end

    // ---------------- long hold on ch0: auto-repeat timing ----------------
    // Rise at edge 5; repeats at 13,16,19,22,25; fall at 26 with no repeat.
    for (int j = 0; j <= 30; j++) begin
      logic [3:0] e_l, e_r, e_f, e_p;
      @(negedge clk);
      din_a = (j <= 20) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      #1;
      e_l = (j >= 5 && j < 26) ? 4'b0001 : 4'b0000;
      e_r = (j == 5)  ? 4'b0001 : 4'b0000;
      e_f = (j == 26) ? 4'b0001 : 4'b0000;
      e_p = (REP_ON && j >= 13 && j <= 25 && ((j - 13) % 3 == 0)) ? 4'b0001 : 4'b0000;
      check($sformatf("hold%0d level", j), 32'(level_a), 32'(e_l));
      check($sformatf("hold%0d rise", j),  32'(rise_a),  32'(e_r));
      check($sformatf("hold%0d fall", j),  32'(fall_a),  32'(e_f));
      check($sformatf("hold%0d rpt", j),   32'(rpt_a),   32'(e_p));
    end

    // ---------------- reset in the middle of a count ----------------
    // ch0 accepted at edge 5; ch3 starts at edge 6 and has 2 samples by edge 9.
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      din_a = (j < 6) ? 4'b0001 : 4'b1001;
      @(posedge clk);
      #1;
      check($sformatf("pre%0d level", j), 32'(level_a), (j >= 5) ? 32'h1 : 32'h0);
      check($sformatf("pre%0d rise", j),  32'(rise_a),  (j == 5) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("async rst level", 32'(level_a), 32'h0);
    check("async rst rise",  32'(rise_a),  32'h0);
    check("async rst fall",  32'(fall_a),  32'h0);
    check("async rst rpt",   32'(rpt_a),   32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("held rst level", 32'(level_a), 32'h0);
    check("held rst rise",  32'(rise_a),  32'h0);
    @(negedge clk);
    rst_a = 1'b1;
    // din still 1001: both channels need the full count again, rising at edge 5.
    for (int j = 0; j <= 6; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("post%0d level", j), 32'(level_a), (j >= 5) ? 32'h9 : 32'h0);
      check($sformatf("post%0d rise", j),  32'(rise_a),  (j == 5) ? 32'h9 : 32'h0);
      check($sformatf("post%0d fall", j),  32'(fall_a),  32'h0);
    end

    // ---------------- prescaled instance and single-sample instance ----------------
    // u_b ticks at edges 4,9,14 after release; din_b[2] is seen from edge 2,
    // so the third agreeing tick (edge 14) accepts it.
    // u_c gets a one-cycle pulse on din_c[0]: level high at edge 2 only.
    @(negedge clk);
    rst_b = 1'b1;
    din_b = 4'b0100;
    din_c = 2'b01;
    for (int j = 0; j <= 19; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("tick%0d level_b", j), 32'(level_b), (j >= 14) ? 32'h4 : 32'h0);
      check($sformatf("tick%0d rise_b", j),  32'(rise_b),  (j == 14) ? 32'h4 : 32'h0);
      check($sformatf("tick%0d fall_b", j),  32'(fall_b),  32'h0);
      check($sformatf("s1_%0d level_c", j),  32'(level_c), (j == 2) ? 32'h1 : 32'h0);
      check($sformatf("s1_%0d rise_c", j),   32'(rise_c),  (j == 2) ? 32'h1 : 32'h0);
      check($sformatf("s1_%0d fall_c", j),   32'(fall_c),  (j == 3) ? 32'h1 : 32'h0);
      @(negedge clk);
      din_c = 2'b00;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
